t_ff_down_counter: RTL and testbench

//   Synchronous N-bit down counter built from per-bit T flip-flops; the

---
 rtl/t_ff_down_counter_if.sv | 11 +
 rtl/t_ff_down_counter.sv | 33 +++
 tb/tb_t_ff_down_counter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/t_ff_down_counter_if.sv
// t_ff_down_counter_if: counter bus; master drives en/load/load_val, slave returns q/tc/underflow
interface t_ff_down_counter_if #(parameter int WIDTH = 2);
  logic en;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic tc;
  logic underflow;
  modport master(output en, load, load_val, input q, tc, underflow);
  modport slave(input en, load, load_val, output q, tc, underflow);
endinterface

// File: rtl/t_ff_down_counter.sv
// t_ff_down_counter: T-flop down counter (clk, async rst_n, bus: en/load/load_val in, q/tc/underflow out); wraps or saturates at 0
module t_ff_down_counter #(
  parameter int WIDTH = 2,
  parameter bit WRAP = 1'b1
) (
  input logic clk,
  input logic rst_n,
  t_ff_down_counter_if.slave bus
);
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] t;
  logic uf_r;
  logic zero;
  assign zero = q_r == '0;
  assign t[0] = bus.en & ~(zero & ~WRAP);
  for (genvar i = 1; i < WIDTH; i++) begin : g_t
    assign t[i] = t[i-1] & ~q_r[i-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_r <= '1;
      uf_r <= 1'b0;
    end else if (bus.load) begin
      q_r <= bus.load_val;
      uf_r <= 1'b0;
    end else begin
      q_r <= q_r ^ t;
      uf_r <= bus.en & zero;
    end
  assign bus.q = q_r;
  assign bus.tc = zero;
  assign bus.underflow = uf_r;
endmodule

// File: tb/tb_t_ff_down_counter.sv
// tb_t_ff_down_counter: random and directed checks of four counter configurations against an arithmetic model
module tb_t_ff_down_counter;
  localparam int N = 4;
  localparam int W[N] = '{2, 2, 4, 1};
  localparam int WR[N] = '{1, 0, 1, 1};
  logic clk, rst_n, en, load, run;
  logic [3:0] lv;
  int total = 0, bad = 0;
  int mq[N], muf[N];
  logic [3:0] dq[N];
  logic duf[N], dtc[N];
  t_ff_down_counter_if #(.WIDTH(2)) b0();
  t_ff_down_counter_if #(.WIDTH(2)) b1();
  t_ff_down_counter_if #(.WIDTH(4)) b2();
  t_ff_down_counter_if #(.WIDTH(1)) b3();
  t_ff_down_counter #(.WIDTH(2), .WRAP(1'b1)) u0(.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  t_ff_down_counter #(.WIDTH(2), .WRAP(1'b0)) u1(.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  t_ff_down_counter #(.WIDTH(4), .WRAP(1'b1)) u2(.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  t_ff_down_counter #(.WIDTH(1), .WRAP(1'b1)) u3(.clk(clk), .rst_n(rst_n), .bus(b3.slave));
  assign {b0.en, b1.en, b2.en, b3.en} = {4{en}};
  assign {b0.load, b1.load, b2.load, b3.load} = {4{load}};
  assign b0.load_val = lv[1:0];
  assign b1.load_val = lv[1:0];
  assign b2.load_val = lv;
  assign b3.load_val = lv[0];
  assign dq[0] = {2'b0, b0.q};
  assign dq[1] = {2'b0, b1.q};
  assign dq[2] = b2.q;
  assign dq[3] = {3'b0, b3.q};
  assign duf = '{b0.underflow, b1.underflow, b2.underflow, b3.underflow};
  assign dtc = '{b0.tc, b1.tc, b2.tc, b3.tc};
  initial begin
    clk = 0;
    forever #100 clk = ~clk;
  end
  task automatic chk(string n, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", n, a, e, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < N; i++) begin
      automatic int mx = (1 << W[i]) - 1;
      if (!rst_n) begin
        mq[i] <= mx;
        muf[i] <= 0;
      end else if (load) begin
        mq[i] <= int'(lv) & mx;
        muf[i] <= 0;
      end else if (en && mq[i] == 0) begin
        mq[i] <= WR[i] ? mx : 0;
        muf[i] <= 1;
      end else if (en) begin
        mq[i] <= mq[i] - 1;
        muf[i] <= 0;
      end else muf[i] <= 0;
    end
  always @(negedge clk)
    if (run)
      for (int i = 0; i < N; i++) begin
        chk($sformatf("model_q[%0d]", i), int'(dq[i]), mq[i]);
        chk($sformatf("model_uf[%0d]", i), int'(duf[i]), muf[i]);
        chk($sformatf("model_tc[%0d]", i), int'(dtc[i]), int'(mq[i] == 0));
      end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  initial begin
    int e2w[5] = '{2, 1, 0, 3, 2};
    int u2w[5] = '{0, 0, 0, 1, 0};
    int e2s[5] = '{2, 1, 0, 0, 0};
    int u2s[5] = '{0, 0, 0, 1, 1};
    int e1[5] = '{0, 1, 0, 1, 0};
    int tg[4] = '{1, 0, 0, 1};
    int tq[4] = '{2, 2, 2, 1};
    int w0[3] = '{0, 3, 2};
    int ufs;
    run = 0;
    rst_n = 0;
    en = 1;
    load = 0;
    lv = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q_w2", int'(dq[0]), 3);
    chk("rst_tc_w2", int'(dtc[0]), 0);
    chk("rst_uf_w2", int'(duf[0]), 0);
    chk("rst_q_w4", int'(dq[2]), 15);
    chk("rst_q_w1", int'(dq[3]), 1);
    @(negedge clk);
    #1;
    rst_n = 1;
    run = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("seq_q_wrap", int'(dq[0]), e2w[k]);
      chk("seq_tc_wrap", int'(dtc[0]), int'(e2w[k] == 0));
      chk("seq_uf_wrap", int'(duf[0]), u2w[k]);
      chk("seq_q_sat", int'(dq[1]), e2s[k]);
      chk("seq_uf_sat", int'(duf[1]), u2s[k]);
      chk("seq_q_w4", int'(dq[2]), 14 - k);
      chk("seq_q_w1", int'(dq[3]), e1[k]);
      chk("seq_uf_w1", int'(duf[3]), e1[k]);
    end
    load = 1;
    lv = 3;
    en = 0;
    tick();
    chk("load3", int'(dq[0]), 3);
    load = 0;
    for (int k = 0; k < 4; k++) begin
      en = tg[k][0];
      tick();
      chk("gate_q", int'(dq[0]), tq[k]);
      chk("gate_uf", int'(duf[0]), 0);
    end
    load = 1;
    lv = 2;
    en = 1;
    tick();
    chk("load_wins", int'(dq[0]), 2);
    load = 0;
    tick();
    chk("after_load", int'(dq[0]), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sat_q", int'(dq[1]), 0);
      chk("sat_tc", int'(dtc[1]), 1);
      chk("sat_uf", int'(duf[1]), int'(k > 0));
      chk("wrap_q", int'(dq[0]), w0[k]);
    end
    load = 1;
    lv = 3;
    tick();
    chk("sat_restore", int'(dq[1]), 3);
    lv = 0;
    tick();
    chk("load0_q", int'(dq[0]), 0);
    chk("load0_uf", int'(duf[0]), 0);
    load = 0;
    tick();
    chk("load0_then_count_uf", int'(duf[0]), 1);
    chk("load0_then_count_q", int'(dq[0]), 3);
    chk("load0_sat_uf", int'(duf[1]), 1);
    chk("w1_q", int'(dq[3]), 1);
    en = 0;
    #50;
    rst_n = 0;
    #1;
    chk("async_q_wrap", int'(dq[0]), 3);
    chk("async_uf_wrap", int'(duf[0]), 0);
    chk("async_q_sat", int'(dq[1]), 3);
    chk("async_uf_sat", int'(duf[1]), 0);
    chk("async_uf_w1", int'(duf[3]), 0);
    tick();
    rst_n = 1;
    for (int k = 0; k < 400; k++) begin
      en = $urandom_range(99) < 75;
      load = $urandom_range(99) < 15;
      lv = 4'($urandom);
      rst_n = $urandom_range(99) >= 3;
      tick();
    end
    rst_n = 0;
    load = 0;
    en = 1;
    tick();
    rst_n = 1;
    ufs = 0;
    for (int k = 0; k < 17; k++) begin
      tick();
      chk("w4_run_q", int'(dq[2]), (30 - k) % 16);
      ufs += int'(duf[2]);
    end
    chk("w4_uf_count", ufs, 1);
    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
